// File: rtl/sd_fifo_b_pkg.sv
// sd_fifo_b_pkg: pointer ops plus wrapped-increment and usage math shared by B FIFO head and tail
package sd_fifo_b_pkg;
  typedef enum logic [1:0] {PTR_HOLD, PTR_INC, PTR_LOAD} ptr_op_e;
  function automatic logic [31:0] wrap_inc(input logic [31:0] ptr, input logic [31:0] bound_low, input logic [31:0] bound_high);
    return (ptr == bound_high) ? bound_low : ptr + 32'd1;
  endfunction
  // Difference is taken at usz+1 bits so a negative result always shows in bit usz.
  function automatic logic [31:0] fifo_usage(input logic [31:0] wrptr, input logic [31:0] rdptr, input logic [31:0] bound_low, input logic [31:0] bound_high, input int usz);
    logic [31:0] mask, tmp;
    mask = (32'd1 << (usz + 1)) - 32'd1;
    tmp = (wrptr - rdptr) & mask;
    return tmp[usz] ? ((bound_high - bound_low + 32'd1) - ((rdptr - wrptr) & mask)) & mask : tmp;
  endfunction
endpackage

// File: rtl/sd_fifo_ptr_b.sv
// sd_fifo_ptr_b: bounded pointer register with wrapped increment and load
module sd_fifo_ptr_b import sd_fifo_b_pkg::*; #(
  parameter int asz = 4
) (
  input  logic           clk,
  input  logic           reset,
  input  logic [asz-1:0] bound_low,
  input  logic [asz-1:0] bound_high,
  input  ptr_op_e        op,
  input  logic [asz-1:0] load_val,
  output logic [asz-1:0] ptr
);
  logic [asz-1:0] ptr_p1;
  always_comb ptr_p1 = asz'(wrap_inc(32'(ptr), 32'(bound_low), 32'(bound_high)));
  always_ff @(posedge clk)
    if (reset) ptr <= bound_low;
    else if (op == PTR_INC) ptr <= ptr_p1;
    else if (op == PTR_LOAD) ptr <= load_val;
endmodule

// File: rtl/sd_fifo_head_b.sv
// sd_fifo_head_b: write-side controller of a memory-based FIFO with optional commit/abort
module sd_fifo_head_b import sd_fifo_b_pkg::*; #(
  parameter int width = 8,
  parameter int depth = 16,
  parameter int commit = 0,
  parameter int asz = $clog2(depth),
  parameter int usz = $clog2(depth + 1)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             enable,
  input  logic [asz-1:0]   bound_low,
  input  logic [asz-1:0]   bound_high,
  input  logic             c_srdy,
  output logic             c_drdy,
  input  logic             c_commit,
  input  logic             c_abort,
  input  logic [width-1:0] c_data,
  input  logic [asz-1:0]   rdptr,
  output logic [asz-1:0]   cur_wrptr,
  output logic [asz-1:0]   com_wrptr,
  output logic             mem_we,
  output logic [asz-1:0]   mem_addr,
  output logic [width-1:0] mem_wr_data,
  output logic [usz:0]     c_usage
);
  logic [asz-1:0] cur_p1, com_reg, com_load;
  logic full, abort;
  ptr_op_e cur_op, com_op;
  always_comb begin
    cur_p1 = asz'(wrap_inc(32'(cur_wrptr), 32'(bound_low), 32'(bound_high)));
    full = cur_p1 == rdptr;
    abort = (commit != 0) && c_abort;
    c_drdy = !reset && enable && !full && !abort;
    mem_we = c_srdy && c_drdy;
    cur_op = abort ? PTR_LOAD : mem_we ? PTR_INC : PTR_HOLD;
    com_op = (commit != 0) && !abort && c_commit ? PTR_LOAD : PTR_HOLD;
    com_load = mem_we ? cur_p1 : cur_wrptr;
  end
  assign mem_addr = cur_wrptr;
  assign mem_wr_data = c_data;
  // Without commit support the committed pointer simply tracks the write pointer.
  assign com_wrptr = (commit != 0) ? com_reg : cur_wrptr;
  assign c_usage = (usz + 1)'(fifo_usage(32'(cur_wrptr), 32'(rdptr), 32'(bound_low), 32'(bound_high), usz));
  sd_fifo_ptr_b #(.asz(asz)) u_cur (
    .clk(clk), .reset(reset), .bound_low(bound_low), .bound_high(bound_high),
    .op(cur_op), .load_val(com_reg), .ptr(cur_wrptr)
  );
  sd_fifo_ptr_b #(.asz(asz)) u_com (
    .clk(clk), .reset(reset), .bound_low(bound_low), .bound_high(bound_high),
    .op(com_op), .load_val(com_load), .ptr(com_reg)
  );
endmodule

// File: tb/tb_sd_fifo_head_b.sv
// tb_sd_fifo_head_b: randomized checks of plain (a_) and commit-mode (b_) heads against a queue-style model
module tb_sd_fifo_head_b;
  logic clk = 0, reset = 1, enable = 1, c_srdy = 0, c_commit = 0, c_abort = 0;
  logic [3:0] bound_low = 0, bound_high = 15, rdptr = 0;
  logic [7:0] c_data = 0;
  logic a_drdy, a_we, b_drdy, b_we;
  logic [3:0] a_cur, a_com, a_addr, b_cur, b_com, b_addr;
  logic [7:0] a_wdata, b_wdata;
  logic [5:0] a_usage, b_usage;
  int total = 0, passed = 0;
  int lo = 0, hi = 15, m_cur = 0, m_com = 0, m_rd = 0;

  always #5 clk = ~clk;

  sd_fifo_head_b #(.width(8), .depth(16), .commit(0)) u_a (
    .clk(clk), .reset(reset), .enable(enable), .bound_low(bound_low), .bound_high(bound_high),
    .c_srdy(c_srdy), .c_drdy(a_drdy), .c_commit(c_commit), .c_abort(c_abort), .c_data(c_data),
    .rdptr(rdptr), .cur_wrptr(a_cur), .com_wrptr(a_com), .mem_we(a_we), .mem_addr(a_addr),
    .mem_wr_data(a_wdata), .c_usage(a_usage)
  );
  sd_fifo_head_b #(.width(8), .depth(16), .commit(1)) u_b (
    .clk(clk), .reset(reset), .enable(enable), .bound_low(bound_low), .bound_high(bound_high),
    .c_srdy(c_srdy), .c_drdy(b_drdy), .c_commit(c_commit), .c_abort(c_abort), .c_data(c_data),
    .rdptr(rdptr), .cur_wrptr(b_cur), .com_wrptr(b_com), .mem_we(b_we), .mem_addr(b_addr),
    .mem_wr_data(b_wdata), .c_usage(b_usage)
  );

  function automatic int nxt(int p);
    return (p - lo + 1) % (hi - lo + 1) + lo;
  endfunction
  function automatic int occ(int w, int r);
    return (w - r + (hi - lo + 1)) % (hi - lo + 1);
  endfunction

  task automatic do_reset(int l, int h);
    lo = l; hi = h; m_cur = l; m_com = l; m_rd = l;
    bound_low = 4'(l); bound_high = 4'(h); rdptr = 4'(l);
    reset = 1; enable = 1; c_srdy = 0; c_commit = 0; c_abort = 0;
    @(posedge clk); #1;
    reset = 0;
  endtask

  task automatic test_reset;
    lo = 3; hi = 12; bound_low = 3; bound_high = 12; rdptr = 3;
    reset = 1; c_srdy = 1; enable = 1;
    @(posedge clk); #1;
    total++; if (a_cur !== 4'd3) $display("FAIL reset_cur_a: got %0d want 3", a_cur); else passed++;
    total++; if (a_com !== 4'd3) $display("FAIL reset_com_a: got %0d want 3", a_com); else passed++;
    total++; if (b_cur !== 4'd3) $display("FAIL reset_cur_b: got %0d want 3", b_cur); else passed++;
    total++; if (b_com !== 4'd3) $display("FAIL reset_com_b: got %0d want 3", b_com); else passed++;
    total++; if (a_drdy !== 1'b0) $display("FAIL reset_drdy_a: got %0b want 0", a_drdy); else passed++;
    total++; if (a_we !== 1'b0) $display("FAIL reset_we_a: got %0b want 0", a_we); else passed++;
    total++; if (b_we !== 1'b0) $display("FAIL reset_we_b: got %0b want 0", b_we); else passed++;
    total++; if (a_usage !== 6'd0) $display("FAIL reset_usage_a: got %0d want 0", a_usage); else passed++;
    c_srdy = 0; reset = 0;
  endtask

  task automatic test_fill;
    logic exp_we;
    int dut_writes = 0;
    do_reset(0, 15);
    for (int i = 0; i < 20; i++) begin
      c_srdy = 1; c_data = 8'($urandom);
      #1;
      exp_we = occ(m_cur, m_rd) < hi - lo;
      total++; if (a_we !== exp_we) $display("FAIL fill_we: cyc %0d got %0b want %0b", i, a_we, exp_we); else passed++;
      total++; if (a_drdy !== exp_we) $display("FAIL fill_drdy: cyc %0d got %0b want %0b", i, a_drdy, exp_we); else passed++;
      total++; if (a_addr !== 4'(m_cur)) $display("FAIL fill_addr: cyc %0d got %0d want %0d", i, a_addr, m_cur); else passed++;
      total++; if (a_wdata !== c_data) $display("FAIL fill_data: got %0h want %0h", a_wdata, c_data); else passed++;
      if (a_we === 1'b1) dut_writes++;
      @(posedge clk); #1;
      if (exp_we) m_cur = nxt(m_cur);
    end
    total++; if (dut_writes != 15) $display("FAIL fill_count: got %0d want 15", dut_writes); else passed++;
    total++; if (a_usage !== 6'd15) $display("FAIL fill_usage: got %0d want 15", a_usage); else passed++;
    total++; if (a_com !== 4'd15) $display("FAIL fill_com: got %0d want 15", a_com); else passed++;
    total++; if (a_drdy !== 1'b0) $display("FAIL fill_full_drdy: got %0b want 0", a_drdy); else passed++;
  endtask

  task automatic test_wrap;
    logic exp_we;
    int prev_addr = -1;
    bit saw_wrap = 0;
    m_rd = 5; rdptr = 5;
    for (int i = 0; i < 40; i++) begin
      c_srdy = (i < 4) || ($urandom_range(3) != 0); c_data = 8'($urandom);
      if (i > 0 && $urandom_range(1) == 1 && occ(m_cur, m_rd) > 0) m_rd = nxt(m_rd);
      rdptr = 4'(m_rd);
      #1;
      exp_we = c_srdy && occ(m_cur, m_rd) < hi - lo;
      total++; if (a_we !== exp_we) $display("FAIL wrap_we: cyc %0d got %0b want %0b", i, a_we, exp_we); else passed++;
      total++; if (a_addr !== 4'(m_cur)) $display("FAIL wrap_addr: cyc %0d got %0d want %0d", i, a_addr, m_cur); else passed++;
      total++; if (a_usage !== 6'(occ(m_cur, m_rd))) $display("FAIL wrap_usage: cyc %0d got %0d want %0d", i, a_usage, occ(m_cur, m_rd)); else passed++;
      total++; if (a_com !== 4'(m_cur)) $display("FAIL wrap_com: cyc %0d got %0d want %0d", i, a_com, m_cur); else passed++;
      if (a_we === 1'b1) begin
        if (prev_addr == 15 && a_addr == 4'd0) saw_wrap = 1;
        prev_addr = int'(a_addr);
      end
      @(posedge clk); #1;
      if (exp_we) m_cur = nxt(m_cur);
    end
    total++; if (!saw_wrap) $display("FAIL wrap_seen: got 0 want 1"); else passed++;
    c_srdy = 0;
  endtask

  task automatic test_bounds;
    logic exp_we;
    do_reset(4, 11);
    for (int i = 0; i < 10; i++) begin
      c_srdy = 1; c_data = 8'($urandom);
      #1;
      exp_we = occ(m_cur, m_rd) < hi - lo;
      total++; if (a_we !== exp_we) $display("FAIL bnd_fill_we: cyc %0d got %0b want %0b", i, a_we, exp_we); else passed++;
      total++; if (a_addr !== 4'(m_cur)) $display("FAIL bnd_fill_addr: cyc %0d got %0d want %0d", i, a_addr, m_cur); else passed++;
      @(posedge clk); #1;
      if (exp_we) m_cur = nxt(m_cur);
    end
    total++; if (a_usage !== 6'd7) $display("FAIL bnd_full_usage: got %0d want 7", a_usage); else passed++;
    total++; if (a_drdy !== 1'b0) $display("FAIL bnd_full_drdy: got %0b want 0", a_drdy); else passed++;
    for (int i = 0; i < 40; i++) begin
      c_srdy = $urandom_range(3) != 0; c_data = 8'($urandom);
      if ($urandom_range(1) == 1 && occ(m_cur, m_rd) > 0) m_rd = nxt(m_rd);
      rdptr = 4'(m_rd);
      #1;
      exp_we = c_srdy && occ(m_cur, m_rd) < hi - lo;
      total++; if (a_we !== exp_we) $display("FAIL bnd_we: cyc %0d got %0b want %0b", i, a_we, exp_we); else passed++;
      total++; if (a_addr < 4'd4 || a_addr > 4'd11 || a_addr !== 4'(m_cur)) $display("FAIL bnd_addr: cyc %0d got %0d want %0d", i, a_addr, m_cur); else passed++;
      total++; if (a_usage !== 6'(occ(m_cur, m_rd))) $display("FAIL bnd_usage: cyc %0d got %0d want %0d", i, a_usage, occ(m_cur, m_rd)); else passed++;
      @(posedge clk); #1;
      if (exp_we) m_cur = nxt(m_cur);
    end
    c_srdy = 0;
  endtask

  task automatic test_abort;
    do_reset(0, 15);
    for (int i = 0; i < 3; i++) begin
      c_srdy = 1; c_data = 8'($urandom);
      #1;
      total++; if (b_we !== 1'b1 || b_addr !== 4'(i)) $display("FAIL abort_pre: cyc %0d got we=%0b addr=%0d want we=1 addr=%0d", i, b_we, b_addr, i); else passed++;
      @(posedge clk); #1;
    end
    c_abort = 1;
    #1;
    total++; if (b_we !== 1'b0 || b_drdy !== 1'b0) $display("FAIL abort_cycle: got we=%0b drdy=%0b want 0 0", b_we, b_drdy); else passed++;
    total++; if (a_we !== 1'b1) $display("FAIL abort_ignored_a: got we=%0b want 1", a_we); else passed++;
    @(posedge clk); #1;
    c_abort = 0;
    total++; if (b_cur !== 4'd0 || b_com !== 4'd0) $display("FAIL abort_ptrs: got cur=%0d com=%0d want 0 0", b_cur, b_com); else passed++;
    total++; if (a_cur !== 4'd4) $display("FAIL abort_ignored_cur_a: got %0d want 4", a_cur); else passed++;
    #1;
    total++; if (b_we !== 1'b1 || b_addr !== 4'd0) $display("FAIL abort_next: got we=%0b addr=%0d want 1 0", b_we, b_addr); else passed++;
    @(posedge clk); #1;
    c_srdy = 0;
  endtask

  task automatic test_commit;
    logic exp_we, exp_drdy, ab, cm;
    do_reset(0, 15);
    c_srdy = 1;
    for (int i = 0; i < 4; i++) begin
      c_commit = i == 3; c_data = 8'($urandom);
      @(posedge clk); #1;
    end
    c_commit = 0;
    total++; if (b_com !== 4'd4 || b_cur !== 4'd4) $display("FAIL commit_4: got cur=%0d com=%0d want 4 4", b_cur, b_com); else passed++;
    repeat (2) begin @(posedge clk); #1; end
    total++; if (b_cur !== 4'd6 || b_com !== 4'd4) $display("FAIL commit_spec: got cur=%0d com=%0d want 6 4", b_cur, b_com); else passed++;
    total++; if (b_usage !== 6'd6) $display("FAIL commit_spec_usage: got %0d want 6", b_usage); else passed++;
    c_abort = 1;
    @(posedge clk); #1;
    total++; if (b_cur !== 4'd4 || b_com !== 4'd4) $display("FAIL commit_abort: got cur=%0d com=%0d want 4 4", b_cur, b_com); else passed++;
    c_commit = 1;
    #1;
    total++; if (b_we !== 1'b0) $display("FAIL commit_abort_prio_we: got %0b want 0", b_we); else passed++;
    @(posedge clk); #1;
    c_abort = 0; c_commit = 0;
    total++; if (b_cur !== 4'd4 || b_com !== 4'd4) $display("FAIL commit_abort_prio: got cur=%0d com=%0d want 4 4", b_cur, b_com); else passed++;
    @(posedge clk); #1;
    c_srdy = 0; c_commit = 1;
    @(posedge clk); #1;
    c_commit = 0;
    total++; if (b_cur !== 4'd5 || b_com !== 4'd5) $display("FAIL commit_nowrite: got cur=%0d com=%0d want 5 5", b_cur, b_com); else passed++;
    m_cur = 5; m_com = 5; m_rd = 0;
    for (int i = 0; i < 80; i++) begin
      c_srdy = $urandom_range(3) != 0; c_data = 8'($urandom);
      cm = $urandom_range(3) == 0; ab = $urandom_range(7) == 0;
      c_commit = cm; c_abort = ab;
      if ($urandom_range(1) == 1 && m_rd != m_com) m_rd = nxt(m_rd);
      rdptr = 4'(m_rd);
      #1;
      exp_drdy = !ab && occ(m_cur, m_rd) < hi - lo;
      exp_we = c_srdy && exp_drdy;
      total++; if (b_drdy !== exp_drdy) $display("FAIL cm_drdy: cyc %0d got %0b want %0b", i, b_drdy, exp_drdy); else passed++;
      total++; if (b_we !== exp_we) $display("FAIL cm_we: cyc %0d got %0b want %0b", i, b_we, exp_we); else passed++;
      total++; if (b_addr !== 4'(m_cur)) $display("FAIL cm_addr: cyc %0d got %0d want %0d", i, b_addr, m_cur); else passed++;
      total++; if (b_usage !== 6'(occ(m_cur, m_rd))) $display("FAIL cm_usage: cyc %0d got %0d want %0d", i, b_usage, occ(m_cur, m_rd)); else passed++;
      @(posedge clk); #1;
      if (ab) m_cur = m_com;
      else begin
        if (exp_we) m_cur = nxt(m_cur);
        if (cm) m_com = m_cur;
      end
      total++; if (b_cur !== 4'(m_cur) || b_com !== 4'(m_com)) $display("FAIL cm_ptrs: cyc %0d got cur=%0d com=%0d want %0d %0d", i, b_cur, b_com, m_cur, m_com); else passed++;
    end
    c_srdy = 0; c_commit = 0; c_abort = 0;
  endtask

  task automatic test_enable;
    do_reset(0, 15);
    c_srdy = 1;
    repeat (2) begin @(posedge clk); #1; end
    enable = 0;
    for (int i = 0; i < 3; i++) begin
      #1;
      total++; if (a_drdy !== 1'b0 || a_we !== 1'b0 || b_we !== 1'b0) $display("FAIL enable_stall: cyc %0d got drdy=%0b we=%0b/%0b want 0", i, a_drdy, a_we, b_we); else passed++;
      @(posedge clk); #1;
    end
    total++; if (a_cur !== 4'd2 || b_cur !== 4'd2) $display("FAIL enable_hold: got %0d/%0d want 2", a_cur, b_cur); else passed++;
    enable = 1; c_srdy = 0;
  endtask

  task automatic test_reset_mid;
    do_reset(0, 15);
    c_srdy = 1;
    repeat (9) begin c_data = 8'($urandom); @(posedge clk); #1; end
    total++; if (a_cur !== 4'd9) $display("FAIL midrst_pre: got %0d want 9", a_cur); else passed++;
    reset = 1;
    #1;
    total++; if (a_we !== 1'b0 || a_drdy !== 1'b0) $display("FAIL midrst_we: got we=%0b drdy=%0b want 0 0", a_we, a_drdy); else passed++;
    @(posedge clk); #1;
    reset = 0;
    total++; if (a_cur !== 4'd0 || a_com !== 4'd0) $display("FAIL midrst_ptrs: got cur=%0d com=%0d want 0 0", a_cur, a_com); else passed++;
    total++; if (a_usage !== 6'd0 || b_cur !== 4'd0) $display("FAIL midrst_usage: got usage=%0d bcur=%0d want 0 0", a_usage, b_cur); else passed++;
    c_srdy = 0;
  endtask

  initial begin
    test_reset;
    test_fill;
    test_wrap;
    test_bounds;
    test_abort;
    test_commit;
    test_enable;
    test_reset_mid;
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
